// File: rtl/scoreboard_regfile.sv
// Register file with a per-register pending-write scoreboard for in-order issue.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module scoreboard_regfile #(
    parameter int REG_WIDTH    = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int ZERO_REG     = 1,
    localparam int ADDR_W      = $clog2(NUM_REGS),
    localparam int CNT_W       = $clog2(NUM_REGS + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [REG_WIDTH-1:0]           wr_data,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD_PORTS*REG_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]        rd_busy,
    input  logic                           iss_en,
    input  logic [ADDR_W-1:0]              iss_addr,
    output logic                           iss_stall,
    output logic [CNT_W-1:0]               busy_count
);

    logic [REG_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]  busy;

    logic wr_is_zero, iss_is_zero;
    logic wr_ok, iss_ok, wr_clears_busy;

    assign wr_is_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    assign iss_is_zero = (ZERO_REG != 0) && (iss_addr == '0);
    assign wr_ok       = wr_en && !wr_is_zero;

    // A writeback retiring the current producer frees the slot in the same cycle.
    assign iss_stall      = iss_en && !iss_is_zero && busy[iss_addr] &&
                            !(wr_en && (wr_addr == iss_addr));
    assign iss_ok         = iss_en && !iss_is_zero && !iss_stall;
    assign wr_clears_busy = wr_ok && busy[wr_addr];

    // NOTE: the data array is reset too, because reset must make every read return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            // NOTE: non-blocking throughout; the later issue assignment overrides the
            // writeback clear on the same bit, so the new producer wins.
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            if (iss_ok) busy[iss_addr] <= 1'b1;
            busy_count <= busy_count + CNT_W'(iss_ok) - CNT_W'(wr_clears_busy);
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0]    ra;
        logic [REG_WIDTH-1:0] data;
        logic                 bsy;

        assign ra = rd_addr[p*ADDR_W +: ADDR_W];

        // NOTE: defaults first so every path assigns data/bsy and no latch is inferred.
        always_comb begin
            data = regs[ra];
            bsy  = busy[ra];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wr_addr == ra)) begin
                data = wr_data;
                bsy  = 1'b0;
            end
`endif
        end

        assign rd_data[p*REG_WIDTH +: REG_WIDTH] = data;
        assign rd_busy[p]                         = bsy;
    end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, data width per register.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count (power of two, >=2); ADDR_W = $clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD_PORTS, default 2, independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads zero, is never written, and is never busy.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 wr_en  input  1  writeback strobe.
REQ-008 wr_addr  input  ADDR_W  writeback destination.
REQ-009 wr_data  input  REG_WIDTH  writeback data.
REQ-010 rd_addr  input  NUM_RD_PORTS*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W].
REQ-011 rd_data  output  NUM_RD_PORTS*REG_WIDTH  read data, port p at [p*REG_WIDTH +: REG_WIDTH].
REQ-012 rd_busy  output  NUM_RD_PORTS  per-port pending-write flag for the addressed register.
REQ-013 iss_en  input  1  issue request: mark iss_addr pending.
REQ-014 iss_addr  input  ADDR_W  issuing instruction's destination.
REQ-015 iss_stall  output  1  issue refused this cycle (WAW hazard).
REQ-016 busy_count  output  $clog2(NUM_REGS+1)  number of registers currently pending.

Function
REQ-017 Reads SHALL be combinational: rd_data/rd_busy reflect current stored state in the same cycle as rd_addr.
REQ-018 On a rising edge with wr_en=1, regs[wr_addr] SHALL take wr_data and busy[wr_addr] SHALL clear; wr_addr=0 with ZERO_REG=1 is a no-op.
REQ-019 iss_stall SHALL equal iss_en & busy[iss_addr] & ~(wr_en & wr_addr==iss_addr); always 0 for iss_addr=0 with ZERO_REG=1.
REQ-020 On a rising edge with iss_en=1 and iss_stall=0, busy[iss_addr] SHALL set; iss_addr=0 with ZERO_REG=1 sets nothing.
REQ-021 Simultaneous wr_en and accepted iss_en to the same address: data written, busy ends set (new producer wins).
REQ-022 busy_count SHALL be registered, changing by +1 (set only), -1 (clear of a busy register only), or 0 (both, neither, or write to a non-busy register); it SHALL always equal popcount(busy).
REQ-023 Writeback to a non-busy register SHALL update data without error or count change.
REQ-024 Multiple read ports addressing the same register SHALL return identical values.

Reset
REQ-025 While rst_n=0, all registers SHALL be 0, all busy bits 0, busy_count 0, hence rd_data 0, rd_busy 0, iss_stall 0 (iss_stall with iss_en asserted is still 0).
REQ-026 Reset asserted mid-operation SHALL discard all pending state immediately; first edge after release behaves as from empty.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN: when defined, a read port whose rd_addr equals wr_addr with wr_en=1 (excluding register 0 under ZERO_REG=1) SHALL return wr_data and rd_busy=0 in that same cycle.
REQ-028 Without REGFILE_BYPASS_EN, that port SHALL return the pre-write stored value and stored busy bit; new data visible the next cycle.

Verification
REQ-029 Reset, then read all addresses on both ports -> rd_data=0, rd_busy=0, busy_count=0.
REQ-030 iss_en addr 5; next cycle iss_en addr 5 again -> iss_stall=1, busy_count stays 1; wr_en addr 5 data 0xDEADBEEF -> busy_count=0, rd_data=0xDEADBEEF on reading port.
REQ-031 Same-cycle wr_en addr 7 data 0x12 and iss_en addr 7 while busy[7]=1 -> iss_stall=0, data 0x12 stored, busy[7]=1, busy_count unchanged.
REQ-032 ZERO_REG=1: wr_en addr 0 data 0xFFFFFFFF, iss_en addr 0 -> rd_data port0=0, rd_busy=0, busy_count=0, iss_stall=0.
REQ-033 wr_en addr 3 data 0xA5 while port1 reads addr 3 -> with REGFILE_BYPASS_EN rd_data=0xA5 same cycle; without, old value then 0xA5 next cycle.
REQ-034 Issue addresses 1..31 back-to-back, assert rst_n=0 mid-sequence -> busy_count=0 immediately, all rd_busy=0 after release.
